uart_rx_cfg: RTL and testbench

Next-generation UART receiver for the uartlite device. Adds the following over the single-rate receiver:
- runtime baud divisor and 16x oversampling with 3-sample majority vote
- parametrised parity and 1/2 stop bits
- parity, framing and break detection
- small first-word-fall-through receive FIFO with valid/ready output and sticky overrun
Sits between the board RX pin and the uartlite register/bus front end.

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_cfg.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_rx_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } rx_state_e;

   // Parity mode encodings for Param_ParityMode
   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // A FIFO entry is {frame_err, parity_err, data}
   function automatic int fifo_entry_width(input int payload_bits);
      return payload_bits + 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. The head entry is visible on pop_data
// whenever empty is low; push and pop may coincide at any fill level.
module uart_rx_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign full     = (count == CNT_FULL);
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap modulo DEPTH; the extra count bit separates full from empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime baud divisor, optional parity,
// 1/2 stop bits, break detection and a small FWFT receive FIFO.
//
// Output handshake: an entry is offered while IO_RxValid_O is high and is
// consumed on every rising clock edge where IO_RxValid_O and IO_RxReady_I are
// both high; data and error flags stay stable until that edge.
module uart_rx_cfg
   import uart_rx_pkg::*;
#(
   parameter int Param_PayloadBits = 8,
   parameter int Param_ParityMode  = 0,
   parameter int Param_StopBits    = 1,
   parameter int Param_DivWidth    = 16,
   parameter int Param_Oversample  = 16,
   parameter int Param_FifoDepth   = 4
) (
   input  logic                         IO_Clk_I,
   input  logic                         IO_Rst_I,
   input  logic                         IO_Rx_I,
   input  logic [Param_DivWidth-1:0]    IO_BaudDiv_I,
   input  logic                         IO_RxReady_I,
   input  logic                         IO_OvrClr_I,
   output logic                         IO_RxValid_O,
   output logic [Param_PayloadBits-1:0] IO_RxData_O,
   output logic                         IO_ParityErr_O,
   output logic                         IO_FrameErr_O,
   output logic                         IO_Overrun_O,
   output logic                         IO_Break_O,
   output rx_state_e                    dbg_state
);

   localparam int PB  = Param_PayloadBits;
   localparam int EW  = fifo_entry_width(PB);
   localparam int OS  = Param_Oversample;
   localparam int OSW = $clog2(OS);

   localparam logic [OSW-1:0] OS_LAST = OSW'(OS - 1);
   localparam logic [OSW-1:0] OS_S0   = OSW'(OS / 2 - 1);
   localparam logic [OSW-1:0] OS_S1   = OSW'(OS / 2);
   localparam logic [OSW-1:0] OS_S2   = OSW'(OS / 2 + 1);
   localparam logic [OSW-1:0] OS_ONE  = OSW'(1);

   localparam logic [Param_DivWidth-1:0] DIV_ONE = Param_DivWidth'(1);

   localparam logic [3:0] LAST_DATA = 4'(PB - 1);
   localparam logic [3:0] LAST_STOP = 4'(Param_StopBits - 1);
   localparam logic       HAS_PAR   = (Param_ParityMode != PARITY_NONE);
   localparam logic       PAR_INV   = (Param_ParityMode == PARITY_ODD);

   rx_state_e                 state;
   logic                      rx_meta;
   logic                      rx_s;
   logic [Param_DivWidth-1:0] div_q;
   logic [Param_DivWidth-1:0] tick_cnt;
   logic [OSW-1:0]            os_cnt;
   logic                      counting;
   logic                      tick;
   logic                      samp_a;
   logic                      samp_b;
   logic                      maj;
   logic                      decide;
   logic [3:0]                bit_cnt;
   logic [PB-1:0]             data_q;
   logic                      perr_q;
   logic                      ferr_q;
   logic                      par_bit_q;
   logic                      stop0_q;
   logic                      first_stop;
   logic                      ferr_next;
   logic                      is_break;
   logic                      push_q;
   logic [EW-1:0]             entry_q;
   logic                      brk_q;
   logic                      ovr_q;
   logic [EW-1:0]             head;
   logic                      full;
   logic                      empty;
   logic                      pop;

   // Two-stage synchroniser preset to the idle level
   always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
      if (!IO_Rst_I) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= IO_Rx_I;
         rx_s    <= rx_meta;
      end
   end

   // Counters only run while a frame is being timed
   assign counting = (state != ST_IDLE) && (state != ST_WAIT_HIGH);
   assign tick     = counting && (tick_cnt == div_q);
   assign decide   = tick && (os_cnt == OS_S2);
   assign maj      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

   // Oversample tick generator and per-bit sample counter
   always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
      if (!IO_Rst_I) begin
         tick_cnt <= '0;
         os_cnt   <= '0;
      end else if (!counting) begin
         tick_cnt <= '0;
         os_cnt   <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
         os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
      end else begin
         tick_cnt <= tick_cnt + DIV_ONE;
      end
   end

   // Capture the two early samples; the third is rx_s at the decision tick
   always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
      if (!IO_Rst_I) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (tick && os_cnt == OS_S0) samp_a <= rx_s;
         if (tick && os_cnt == OS_S1) samp_b <= rx_s;
      end
   end

   // Stop-bit bookkeeping: break looks at the first stop bit, framing at all
   assign first_stop = (bit_cnt == 4'd0) ? maj : stop0_q;
   assign ferr_next  = ferr_q | ~maj;
   assign is_break   = (data_q == '0) && !par_bit_q && !first_stop;

   // Frame FSM with registered push, entry and break pulse
   always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
      if (!IO_Rst_I) begin
         state     <= ST_IDLE;
         div_q     <= '0;
         bit_cnt   <= '0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         par_bit_q <= 1'b0;
         stop0_q   <= 1'b1;
         push_q    <= 1'b0;
         entry_q   <= '0;
         brk_q     <= 1'b0;
      end else begin
         push_q <= 1'b0;
         brk_q  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!rx_s) begin
                  state     <= ST_START;
                  div_q     <= IO_BaudDiv_I;
                  bit_cnt   <= '0;
                  data_q    <= '0;
                  perr_q    <= 1'b0;
                  ferr_q    <= 1'b0;
                  par_bit_q <= 1'b0;
               end
            end
            ST_START: begin
               if (decide) state <= maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (decide) begin
                  // LSB arrives first, so shift in from the top
                  data_q <= {maj, data_q[PB-1:1]};
                  if (bit_cnt == LAST_DATA) begin
                     bit_cnt <= '0;
                     state   <= HAS_PAR ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (decide) begin
                  par_bit_q <= maj;
                  perr_q    <= maj ^ (^data_q) ^ PAR_INV;
                  state     <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (decide) begin
                  ferr_q <= ferr_next;
                  if (bit_cnt == 4'd0) stop0_q <= maj;
                  if (bit_cnt == LAST_STOP) begin
                     bit_cnt <= '0;
                     if (is_break) begin
                        brk_q <= 1'b1;
                        state <= ST_WAIT_HIGH;
                     end else begin
                        push_q  <= 1'b1;
                        entry_q <= {ferr_next, perr_q, data_q};
                        state   <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
            end
            ST_WAIT_HIGH: begin
               if (rx_s) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   uart_rx_fifo #(
      .W     (EW),
      .DEPTH (Param_FifoDepth)
   ) u_fifo (
      .clk       (IO_Clk_I),
      .rst_n     (IO_Rst_I),
      .push      (push_q),
      .push_data (entry_q),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   assign pop = IO_RxValid_O & IO_RxReady_I;

   // Sticky overrun: a push dropped at full; set beats clear
   always_ff @(posedge IO_Clk_I or negedge IO_Rst_I) begin
      if (!IO_Rst_I) begin
         ovr_q <= 1'b0;
      end else if (push_q && full && !pop) begin
         ovr_q <= 1'b1;
      end else if (IO_OvrClr_I) begin
         ovr_q <= 1'b0;
      end
   end

   // Head fields are forced to zero while empty so unwritten storage never shows
   assign IO_RxValid_O   = ~empty;
   assign IO_RxData_O    = empty ? '0 : head[PB-1:0];
   assign IO_ParityErr_O = ~empty & head[PB];
   assign IO_FrameErr_O  = ~empty & head[PB+1];
   assign IO_Overrun_O   = ovr_q;
   assign IO_Break_O     = brk_q;
   assign dbg_state      = state;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames plus randomized traffic checked
// against a frame-level model and an expected-entry queue.
module tb_uart_rx_cfg;
   import uart_rx_pkg::*;

   localparam int OS = 16;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT (no parity) ----------------
   logic        rx = 1'b1;
   logic [15:0] baud_div = 16'd3;
   logic        ready = 1'b1;
   logic        ovr_clr = 1'b0;
   logic        valid, perr, ferr, ovr, brk;
   logic [7:0]  data;
   rx_state_e   dut_state;

   uart_rx_cfg dut (
      .IO_Clk_I       (clk),
      .IO_Rst_I       (rst_n),
      .IO_Rx_I        (rx),
      .IO_BaudDiv_I   (baud_div),
      .IO_RxReady_I   (ready),
      .IO_OvrClr_I    (ovr_clr),
      .IO_RxValid_O   (valid),
      .IO_RxData_O    (data),
      .IO_ParityErr_O (perr),
      .IO_FrameErr_O  (ferr),
      .IO_Overrun_O   (ovr),
      .IO_Break_O     (brk),
      .dbg_state      (dut_state)
   );

   // ---------------- DUT (even parity) ----------------
   logic        rx_p = 1'b1;
   logic [15:0] baud_div_p = 16'd3;
   logic        ready_p = 1'b0;
   logic        ovr_clr_p = 1'b0;
   logic        valid_p, perr_p, ferr_p, ovr_p, brk_p;
   logic [7:0]  data_p;
   rx_state_e   dut_state_p;

   uart_rx_cfg #(.Param_ParityMode(1)) dut_p (
      .IO_Clk_I       (clk),
      .IO_Rst_I       (rst_n),
      .IO_Rx_I        (rx_p),
      .IO_BaudDiv_I   (baud_div_p),
      .IO_RxReady_I   (ready_p),
      .IO_OvrClr_I    (ovr_clr_p),
      .IO_RxValid_O   (valid_p),
      .IO_RxData_O    (data_p),
      .IO_ParityErr_O (perr_p),
      .IO_FrameErr_O  (ferr_p),
      .IO_Overrun_O   (ovr_p),
      .IO_Break_O     (brk_p),
      .dbg_state      (dut_state_p)
   );

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [9:0] exp_q[$];
   int pop_cnt      = 0;
   int last_pop_cyc = 0;
   int brk_hi       = 0;
   logic seen_wait  = 1'b0;

   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         if (valid && ready) begin
            pop_cnt++;
            last_pop_cyc = cyc;
            if (exp_q.size() == 0) check("spurious_entry", 32'(exp_q.size()), 32'd1);
            else check("entry", 32'({ferr, perr, data}), 32'(exp_q.pop_front()));
         end
         if (brk) brk_hi++;
         if (dut_state == ST_WAIT_HIGH) seen_wait = 1'b1;
      end
   end

   // ---------------- drivers ----------------
   int start_cyc = 0;

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic drive_line(input bit sel, input logic v);
      if (sel) rx_p = v;
      else     rx   = v;
   endtask

   task automatic hold_bit(input int div);
      repeat ((div + 1) * OS) @(negedge clk);
   endtask

   // One serial frame, LSB first; scramble disturbs the divisor mid-frame
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                             input logic pbit, input logic stop, input int div,
                             input bit scramble);
      @(negedge clk);
      if (sel) baud_div_p = 16'(div);
      else     baud_div   = 16'(div);
      drive_line(sel, 1'b0);
      start_cyc = cyc;
      hold_bit(div);
      if (scramble) begin
         if (sel) baud_div_p = 16'($urandom_range(0, 7));
         else     baud_div   = 16'($urandom_range(0, 7));
      end
      for (int i = 0; i < 8; i++) begin
         drive_line(sel, d[i]);
         hold_bit(div);
      end
      if (has_par) begin
         drive_line(sel, pbit);
         hold_bit(div);
      end
      drive_line(sel, stop);
      hold_bit(div);
      drive_line(sel, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   int p0, b0, brk_exp, push_exp, fifo_cnt;
   logic [7:0] d;
   logic       pbit, stop;
   int         div;

   initial begin
      // reset state
      wait_cycles(3);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_ovr", 32'(ovr), 32'd0);
      check("rst_brk", 32'(brk), 32'd0);
      check("rst_errs", 32'({perr, ferr}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(5);
      check("post_rst_state", 32'(dut_state), 32'(ST_IDLE));
      check("post_rst_valid", 32'(valid), 32'd0);

      // 8N1 0xA5, latency from start edge to first valid cycle
      p0 = pop_cnt;
      exp_q.push_back({2'b00, 8'hA5});
      send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 3, 0);
      wait_cycles(100);
      check("a5_pops", 32'(pop_cnt - p0), 32'd1);
      check("a5_latency", 32'(last_pop_cyc - start_cyc), 32'd620);

      // short low glitch must be rejected at the start decision
      p0 = pop_cnt; b0 = brk_hi;
      @(negedge clk); rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      wait_cycles(200);
      check("glitch_pops", 32'(pop_cnt - p0), 32'd0);
      check("glitch_brk", 32'(brk_hi - b0), 32'd0);
      check("glitch_state", 32'(dut_state), 32'(ST_IDLE));

      // even parity: two directed frames then random ones
      for (int i = 0; i < 6; i++) begin
         d    = (i < 2) ? 8'h01 : 8'($urandom);
         pbit = (i < 2) ? i[0] : 1'($urandom);
         send_frame(1, d, 1, pbit, 1'b1, 3, 0);
         wait_cycles(5);
         check("par_valid", 32'(valid_p), 32'd1);
         check("par_entry", 32'({ferr_p, perr_p, data_p}), 32'({1'b0, ^{d, pbit}, d}));
         @(negedge clk); ready_p = 1'b1;
         @(negedge clk); ready_p = 1'b0;
         #2;
         check("par_popped", 32'(valid_p), 32'd0);
      end

      // framing error, line returns high one bit later, then a clean frame
      p0 = pop_cnt; seen_wait = 1'b0;
      exp_q.push_back({2'b10, 8'h55});
      send_frame(0, 8'h55, 0, 1'b0, 1'b0, 3, 0);
      wait_cycles(20);
      check("ferr_pops", 32'(pop_cnt - p0), 32'd1);
      check("ferr_wait_high", 32'(seen_wait), 32'd1);
      check("ferr_state", 32'(dut_state), 32'(ST_IDLE));
      exp_q.push_back({2'b00, 8'h3C});
      send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 3, 0);
      wait_cycles(20);
      check("clean_pops", 32'(pop_cnt - p0), 32'd2);

      // break: line low for 12 bit times
      p0 = pop_cnt; b0 = brk_hi;
      @(negedge clk); rx = 1'b0;
      repeat (12 * 4 * OS) @(negedge clk);
      #2;
      check("brk_pulse_cycles", 32'(brk_hi - b0), 32'd1);
      check("brk_state", 32'(dut_state), 32'(ST_WAIT_HIGH));
      check("brk_no_push", 32'(valid), 32'd0);
      @(negedge clk); rx = 1'b1;
      wait_cycles(20);
      check("brk_idle", 32'(dut_state), 32'(ST_IDLE));
      check("brk_pops", 32'(pop_cnt - p0), 32'd0);

      // randomized traffic, random divisor, occasional bad stop bits
      p0 = pop_cnt; b0 = brk_hi; brk_exp = 0; push_exp = 0;
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         if (n % 8 == 7) d = 8'h00;
         div  = $urandom_range(0, 3);
         stop = ($urandom_range(0, 3) != 0);
         if (d == 8'h00 && !stop) brk_exp++;
         else begin
            exp_q.push_back({~stop, 1'b0, d});
            push_exp++;
         end
         send_frame(0, d, 0, 1'b0, stop, div, 1);
         repeat ($urandom_range(2, 30)) @(negedge clk);
      end
      wait_cycles(50);
      check("rand_pops", 32'(pop_cnt - p0), 32'(push_exp));
      check("rand_breaks", 32'(brk_hi - b0), 32'(brk_exp));
      check("rand_drained", 32'(exp_q.size()), 32'd0);
      check("rand_no_ovr", 32'(ovr), 32'd0);

      // overrun: consumer stalled, five frames into four slots
      ready = 1'b0; fifo_cnt = 0; p0 = pop_cnt;
      for (int i = 0; i < 5; i++) begin
         d = 8'h10 + 8'(i);
         if (fifo_cnt < 4) begin
            exp_q.push_back({2'b00, d});
            fifo_cnt++;
         end
         send_frame(0, d, 0, 1'b0, 1'b1, 3, 0);
      end
      wait_cycles(10);
      check("ovr_set", 32'(ovr), 32'd1);
      check("ovr_head", 32'(data), 32'h10);
      @(negedge clk); ovr_clr = 1'b1;
      @(negedge clk); ovr_clr = 1'b0;
      #2;
      check("ovr_clr", 32'(ovr), 32'd0);
      @(negedge clk); ready = 1'b1;
      wait_cycles(10);
      check("ovr_pops", 32'(pop_cnt - p0), 32'd4);
      check("ovr_drained", 32'(valid), 32'd0);

      // reset in the middle of a frame with an entry held
      ready = 1'b0;
      exp_q.push_back({2'b00, 8'h77});
      send_frame(0, 8'h77, 0, 1'b0, 1'b1, 3, 0);
      wait_cycles(5);
      check("pre_rst_valid", 32'(valid), 32'd1);
      @(negedge clk); rx = 1'b0;
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #2;
      exp_q.delete();
      check("midrst_outs", 32'({valid, perr, ferr, ovr, brk}), 32'd0);
      check("midrst_data", 32'(data), 32'd0);
      check("midrst_state", 32'(dut_state), 32'(ST_IDLE));
      rx = 1'b1; ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(200);
      check("after_rst_state", 32'(dut_state), 32'(ST_IDLE));
      check("after_rst_valid", 32'(valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
